program_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the single-cycle RISC-V core's instruction memory. It accepts a framed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words. Each word is written into instruction memory at consecutive word addresses. The core's reset is held asserted until the whole image is committed, then released.

---
 rtl/program_loader.sv | 200 ++++++++++++++++++++
 tb/tb_program_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time program loader: framed byte stream -> little-endian 32-bit words -> instruction memory.
// Latency: im_we one clock after the 4th byte of a word is accepted; done two clocks after the last frame byte.
// Backpressure: rx_ready depends only on state and writes never stall the stream, so at most one byte per clock.
//
// Ports:
//   clk, reset (async, active-high), start (single-cycle load request)
//   rx_valid / rx_data / rx_ready : byte stream in (valid/ready)
//   im_we / im_addr / im_wdata    : instruction memory write port (word-aligned byte address)
//   cpu_reset, busy, done, error  : core reset and load status
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
// Frame: LEN_LO LEN_HI, then N*4 data bytes (byte 0 of each word first), then [CHK].

module program_loader #(
  parameter int IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int          IDX_W = $clog2(IMEM_WORDS + 1);
  localparam logic [16:0] MAX_N = 17'(IMEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [23:0]        asm_q, asm_d;     // first three bytes of the word in flight
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  logic               accept;
  logic [15:0]        n_full;
  state_t             end_state;        // where a frame goes once its data is complete

`ifdef LOADER_CHECKSUM_EN
  assign end_state = S_CHK;
`else
  assign end_state = S_FLUSH;
`endif

  // Status outputs are pure decodes of the state register.
  assign rx_ready  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                  || (state_q == S_CHK)
`endif
                  ;
  assign busy      = rx_ready || (state_q == S_FLUSH);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);
  assign cpu_reset = (state_q != S_DONE);

  assign im_we     = we_q;
  assign im_addr   = addr_q;
  assign im_wdata  = wdata_q;

  assign accept    = rx_valid && rx_ready;
  assign n_full    = {rx_data, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    if (accept) begin
      sum_d = sum_q + rx_data;
    end
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_LO;
          byte_cnt_d = '0;
          word_idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = rx_data;
          if ({1'b0, n_full} > MAX_N) begin
            state_d = S_ERR;
          end else if (n_full == 16'd0) begin
            state_d = end_state;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Word complete: register the write so it appears the following cycle.
            we_d       = 1'b1;
            wdata_d    = {rx_data, asm_q};
            addr_d     = 32'(word_idx_q) << 2;
            word_idx_d = word_idx_q + 1'b1;
            if (16'(word_idx_q) + 16'd1 == len_q) begin
              state_d = end_state;
            end
          end else begin
            asm_d = {rx_data, asm_q[23:8]};
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          // Whole frame including this byte must sum to zero mod 256.
          state_d = (8'(sum_q + rx_data) == 8'd0) ? S_FLUSH : S_ERR;
        end
      end
`endif

      S_FLUSH: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected memory writes, a monitor pops them on im_we.
// Status timing (done / error / cpu_reset) is checked inline against the frame-level rules.
// Random word contents, frame lengths and inter-byte gaps come from $urandom.
`timescale 1ns/1ps

module tb_program_loader;

  localparam int IMEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  program_loader #(.IMEM_WORDS(IMEM_WORDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] cur_words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      if (exp_addr.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write (t=%0t)",
                 im_addr, im_wdata, $time);
      end else begin
        logic [31:0] ea;
        logic [31:0] ed;
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        check("wr_addr", im_addr, ea);
        check("wr_data", im_wdata, ed);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that consumed the byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    rx_valid = 1'b0;
    if (!ok) begin
      chk_cnt++;
      $display("FAIL byte_accept: byte %h not accepted within 64 cycles", b);
    end
  endtask

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Sends cur_words as a complete frame and checks the outcome.
  task automatic run_frame(input int gap_lo, input int gap_hi, input bit bad_chk);
    logic [7:0] bytes[$];
    int n = cur_words.size();
    bit ok = 1'b1;
    bytes.push_back(8'(n));
    bytes.push_back(8'(n >> 8));
    foreach (cur_words[i]) begin
      exp_addr.push_back(32'(i * 4));
      exp_data.push_back(cur_words[i]);
      for (int k = 0; k < 4; k++) bytes.push_back(cur_words[i][8*k +: 8]);
    end
`ifdef LOADER_CHECKSUM_EN
    begin
      int sum = 0;
      foreach (bytes[j]) sum += int'(bytes[j]);
      bytes.push_back(8'((256 - sum % 256) % 256 + (bad_chk ? 1 : 0)));
      ok = !bad_chk;
    end
`else
    if (bad_chk) $display("note: checksum corruption requested without checksum support");
`endif
    foreach (bytes[j]) send_byte(bytes[j], int'($urandom_range(gap_hi, gap_lo)));
    @(negedge clk);
    if (ok) begin
      check("flush_done", done, 1'b0);
      check("flush_cpu_reset", cpu_reset, 1'b1);
      check("flush_busy", busy, 1'b1);
      @(negedge clk);
      check("done", done, 1'b1);
      check("release_cpu_reset", cpu_reset, 1'b0);
      check("done_busy", busy, 1'b0);
      check("done_rx_ready", rx_ready, 1'b0);
      check("done_error", error, 1'b0);
    end else begin
      check("chk_error", error, 1'b1);
      check("chk_cpu_reset", cpu_reset, 1'b1);
      check("chk_done", done, 1'b0);
      check("chk_rx_ready", rx_ready, 1'b0);
    end
  endtask

  task automatic random_words(input int n);
    cur_words.delete();
    for (int i = 0; i < n; i++) cur_words.push_back($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_im_we", im_we, 1'b0);
    check("rst_im_addr", im_addr, 32'h0);
    check("rst_im_wdata", im_wdata, 32'h0);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Basic load of the two-instruction image.
    do_start();
    cur_words.delete();
    cur_words.push_back(32'h00500093);
    cur_words.push_back(32'h00108113);
    run_frame(0, 0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // Same image with a corrupted checksum: writes still land, image not released.
    do_start();
    run_frame(0, 0, 1'b1);
`endif

    // Oversize word count: 257 > IMEM_WORDS.
    do_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    check("oversize_error", error, 1'b1);
    check("oversize_rx_ready", rx_ready, 1'b0);
    check("oversize_busy", busy, 1'b0);
    check("oversize_cpu_reset", cpu_reset, 1'b1);

    // Stalled stream: valid drops for one cycle before every byte.
    do_start();
    cur_words.delete();
    cur_words.push_back(32'hDEADBEEF);
    run_frame(1, 1, 1'b0);

    // Reset after two of four data bytes.
    do_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b1;
    #1;
    check("midrst_rx_ready", rx_ready, 1'b0);
    check("midrst_im_we", im_we, 1'b0);
    check("midrst_im_addr", im_addr, 32'h0);
    check("midrst_im_wdata", im_wdata, 32'h0);
    check("midrst_cpu_reset", cpu_reset, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_error", error, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    do_start();
    random_words(3);
    run_frame(0, 2, 1'b0);

    // Reload from DONE: core goes back into reset on the start edge.
    do_start();
    check("reload_cpu_reset", cpu_reset, 1'b1);
    check("reload_done", done, 1'b0);
    check("reload_busy", busy, 1'b1);
    random_words(5);
    run_frame(0, 3, 1'b0);

    // Random frames, including empty ones.
    for (int f = 0; f < 6; f++) begin
      do_start();
      random_words(int'($urandom_range(12, 0)));
      run_frame(0, 2, 1'b0);
    end

    // Largest legal image.
    do_start();
    random_words(IMEM_WORDS);
    run_frame(0, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("writes_drained", 32'(exp_addr.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
